irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Consumer side of the machine interrupt-pending path.
- Synchronises raw machine external, timer and software interrupt lines into a pending vector laid out as the mip CSR.
- Masks that vector with mie and mstatus.MIE, picks the winning interrupt by privileged-spec priority, and raises a held trap request to the pipeline's trap unit.
- Tracks handler residency until mret, so it never re-requests while a handler runs.

Parameters:
- SYNC_STAGES, 2, number of flops in each input synchroniser (minimum 2).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- meip_in  in  1  raw external interrupt level (asynchronous)
- mtip_in  in  1  raw timer interrupt level (asynchronous)
- msip_in  in  1  raw software interrupt level (asynchronous)
- mie  in  32  machine interrupt-enable CSR value (bits 11, 7, 3 used)
- mstatus_mie  in  1  global machine interrupt enable
- trap_ack  in  1  pipeline accepted the trap this cycle
- mret  in  1  mret retired this cycle
- mip  out  32  pending vector: bit 11 = MEIP, bit 7 = MTIP, bit 3 = MSIP, all other bits 0
- trap_req  out  1  interrupt trap requested
- trap_cause  out  32  mcause value for the request
- in_handler  out  1  interrupt handler active

Behaviour:
- Reset: rst sampled high at a clk edge clears every synchroniser flop, mip = 0, state = IDLE, trap_req = 0, trap_cause = 0, in_handler = 0. This holds regardless of current state, including reset mid-request or mid-handler.
- Synchroniser:
  - Each raw input passes through SYNC_STAGES flops.
  - The mip bit equals the last stage, so mip reflects an input change SYNC_STAGES cycles later.
  - Levels are not latched: mip drops when the source drops.
- Eligible vector: elig = mip & mie, gated by mstatus_mie.
- Priority: MEI (cause code 11) > MSI (code 3) > MTI (code 7).
- Cause encoding: trap_cause = {1'b1, 27'b0, code[3:0]}.
- FSM states: IDLE, REQ, HANDLER.
  - IDLE:
    - If mstatus_mie and elig != 0 at the clk edge: register the winning cause, go to REQ.
    - trap_req asserts in the cycle after mip shows the bit, so total latency from raw input = SYNC_STAGES + 1 cycles.
    - trap_ack and mret are ignored in IDLE.
  - REQ:
    - trap_req = 1 and trap_cause is held constant.
    - The request is committed: it stays asserted even if the source, mie or mstatus_mie drops before ack.
    - A higher-priority interrupt arriving in REQ does not replace the registered cause.
    - trap_ack -> HANDLER, with trap_req low from the next cycle.
    - mret while in REQ is ignored.
  - HANDLER:
    - in_handler = 1, trap_req = 0, trap_cause keeps its last value.
    - mret -> IDLE.
    - Pending interrupts are not evaluated in this state.
  - Simultaneous mret and pending in HANDLER: go to IDLE and re-evaluate on the following edge, giving one guaranteed idle cycle.
  - Simultaneous trap_ack and mret in REQ: trap_ack wins, go to HANDLER.
- All outputs are registered; there is no combinational path from any input to any output.

Decomposition:
- Shared CSR package holds:
  - mip/mie bit index constants: MEI = 11, MTI = 7, MSI = 3
  - interrupt cause codes
  - the mcause interrupt-flag bit position
  - the FSM state enum
- One natural sub-module: irq_sync, a parameterised SYNC_STAGES-deep single-bit synchroniser with synchronous reset, instantiated three times.

Test Plan:
- Reset, then mtip_in = 1 with mie = 0x80 and mstatus_mie = 1 -> mip = 0x80 after 2 cycles; trap_req = 1 and trap_cause = 0x80000007 at cycle 3.
- meip_in, mtip_in and msip_in all rise in the same cycle, mie = 0x888 -> trap_cause = 0x8000000B; after trap_ack and mret with MEI cleared and MSI still pending -> next cause = 0x80000003.
- Pending MTI with mie = 0x80 but mstatus_mie = 0 -> trap_req stays 0 for 20 cycles; set mstatus_mie = 1 -> trap_req rises 1 cycle later.
- In REQ, deassert mtip_in and clear mie -> trap_req remains 1 with cause 0x80000007 until trap_ack; then in_handler = 1; mret -> IDLE with no new request.
- In HANDLER, assert mret while msip_in is pending -> one cycle with trap_req = 0 and in_handler = 0, then trap_req = 1 with cause 0x80000003.
- Assert rst during REQ -> next cycle trap_req = 0, mip = 0, in_handler = 0; the held input re-requests after SYNC_STAGES + 1 cycles once rst is released.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared machine-interrupt CSR layout: mip/mie bit positions, cause codes and controller states.
// Imported by the interrupt controller and anything that decodes its mcause value.
package irq_ctrl_pkg;

  localparam int MEI_BIT = 11;
  localparam int MTI_BIT = 7;
  localparam int MSI_BIT = 3;

  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MSI = 4'd3;

  localparam int MCAUSE_INT_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HANDLER = 2'd2
  } irq_state_t;

  function automatic logic [31:0] make_cause(input logic [3:0] code);
    logic [31:0] c;
    c = 32'd0;
    c[MCAUSE_INT_BIT] = 1'b1;
    c[3:0] = code;
    return c;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Single-bit level synchroniser, SYNC_STAGES flops deep, synchronous active-high clear.
// Latency SYNC_STAGES cycles; no flow control, the level is simply re-timed.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Machine interrupt controller: synchronises raw lines into mip, arbitrates, and holds a trap request.
// Raw input to trap_req is SYNC_STAGES+1 cycles; a request is held until trap_ack, then silent until mret.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        meip_in,
  input  logic        mtip_in,
  input  logic        msip_in,
  input  logic [31:0] mie,
  input  logic        mstatus_mie,
  input  logic        trap_ack,
  input  logic        mret,
  output logic [31:0] mip,
  output logic        trap_req,
  output logic [31:0] trap_cause,
  output logic        in_handler
);

  logic meip_s, mtip_s, msip_s;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mei (.clk(clk), .rst(rst), .d(meip_in), .q(meip_s));
  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mti (.clk(clk), .rst(rst), .d(mtip_in), .q(mtip_s));
  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_msi (.clk(clk), .rst(rst), .d(msip_in), .q(msip_s));

  always_comb begin
    mip = 32'd0;
    mip[MEI_BIT] = meip_s;
    mip[MTI_BIT] = mtip_s;
    mip[MSI_BIT] = msip_s;
  end

  logic [31:0] elig;
  logic [3:0]  win_code;

  assign elig = mip & mie & {32{mstatus_mie}};

  // Privileged-spec order: external beats software beats timer.
  always_comb begin
    win_code = CAUSE_MTI;
    if (elig[MEI_BIT]) begin
      win_code = CAUSE_MEI;
    end else if (elig[MSI_BIT]) begin
      win_code = CAUSE_MSI;
    end
  end

  irq_state_t  state_q, state_d;
  logic [31:0] cause_q, cause_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cause_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Cause is captured only on IDLE->REQ, so it stays frozen through REQ and HANDLER.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          state_d = ST_REQ;
          cause_d = make_cause(win_code);
        end
      end
      ST_REQ: begin
        if (trap_ack) begin
          state_d = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (mret) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign trap_req   = (state_q == ST_REQ);
  assign in_handler = (state_q == ST_HANDLER);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with a queue of expected output values checked after each step.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        meip_in, mtip_in, msip_in;
  logic [31:0] mie;
  logic        mstatus_mie, trap_ack, mret;
  logic [31:0] mip;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic        in_handler;

  always #5 clk = ~clk;

  irq_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in),
    .mie(mie), .mstatus_mie(mstatus_mie),
    .trap_ack(trap_ack), .mret(mret),
    .mip(mip), .trap_req(trap_req), .trap_cause(trap_cause), .in_handler(in_handler)
  );

  localparam int SEL_MIP   = 0;
  localparam int SEL_REQ   = 1;
  localparam int SEL_CAUSE = 2;
  localparam int SEL_IH    = 3;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_MIP:   return mip;
      SEL_REQ:   return {31'd0, trap_req};
      SEL_CAUSE: return trap_cause;
      default:   return {31'd0, in_handler};
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      vectors++;
      assert (o === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic expect_all(input string tag, input logic [31:0] m, input logic r,
                            input logic [31:0] c, input logic ih);
    push({tag, ".mip"}, SEL_MIP, m);
    push({tag, ".req"}, SEL_REQ, {31'd0, r});
    push({tag, ".cause"}, SEL_CAUSE, c);
    push({tag, ".ih"}, SEL_IH, {31'd0, ih});
    drain();
  endtask

  initial begin
    rst = 1'b1;
    meip_in = 1'b0; mtip_in = 1'b0; msip_in = 1'b0;
    mie = 32'd0; mstatus_mie = 1'b0; trap_ack = 1'b0; mret = 1'b0;
    cyc(3);
    expect_all("reset", 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;

    // Timer interrupt: two synchroniser cycles, then one more for the request.
    mie = 32'h80; mstatus_mie = 1'b1; mtip_in = 1'b1;
    cyc(1); expect_all("mti_c1", 32'h0, 1'b0, 32'h0, 1'b0);
    cyc(1); expect_all("mti_c2", 32'h80, 1'b0, 32'h0, 1'b0);
    cyc(1); expect_all("mti_c3", 32'h80, 1'b1, 32'h8000_0007, 1'b0);

    // Request is committed even after source and enables vanish.
    mtip_in = 1'b0; mie = 32'h0; mstatus_mie = 1'b0; mret = 1'b1;
    cyc(4); expect_all("req_hold", 32'h0, 1'b1, 32'h8000_0007, 1'b0);
    mret = 1'b0; trap_ack = 1'b1;
    cyc(1); expect_all("ack_handler", 32'h0, 1'b0, 32'h8000_0007, 1'b1);
    trap_ack = 1'b0; mret = 1'b1;
    cyc(1); expect_all("mret_idle", 32'h0, 1'b0, 32'h8000_0007, 1'b0);
    mret = 1'b0;
    cyc(3); expect_all("no_rereq", 32'h0, 1'b0, 32'h8000_0007, 1'b0);

    // Global enable gates an otherwise eligible timer interrupt.
    mie = 32'h80; mtip_in = 1'b1;
    cyc(20); expect_all("mstatus_gate", 32'h80, 1'b0, 32'h8000_0007, 1'b0);
    mstatus_mie = 1'b1;
    cyc(1); expect_all("mstatus_on", 32'h80, 1'b1, 32'h8000_0007, 1'b0);
    trap_ack = 1'b1;
    cyc(1); trap_ack = 1'b0; mtip_in = 1'b0;
    cyc(3); expect_all("h_mti_clear", 32'h0, 1'b0, 32'h8000_0007, 1'b1);
    mret = 1'b1;
    cyc(1); mret = 1'b0;
    cyc(2); expect_all("idle_again", 32'h0, 1'b0, 32'h8000_0007, 1'b0);

    // All three at once: external wins, then software over timer.
    mie = 32'h888; meip_in = 1'b1; mtip_in = 1'b1; msip_in = 1'b1;
    cyc(3); expect_all("all3", 32'h888, 1'b1, 32'h8000_000B, 1'b0);
    trap_ack = 1'b1;
    cyc(1); trap_ack = 1'b0; meip_in = 1'b0;
    cyc(3); expect_all("h_mei_clear", 32'h088, 1'b0, 32'h8000_000B, 1'b1);
    mret = 1'b1;
    cyc(1); mret = 1'b0;
    expect_all("idle_gap", 32'h088, 1'b0, 32'h8000_000B, 1'b0);
    cyc(1); expect_all("msi_next", 32'h088, 1'b1, 32'h8000_0003, 1'b0);

    // Higher priority arriving in REQ must not replace the held cause.
    meip_in = 1'b1;
    cyc(3); expect_all("no_preempt", 32'h888, 1'b1, 32'h8000_0003, 1'b0);
    meip_in = 1'b0;

    // Reset mid-request, then re-request after release.
    rst = 1'b1;
    cyc(1); expect_all("rst_in_req", 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    cyc(2); expect_all("post_rst_c2", 32'h088, 1'b0, 32'h0, 1'b0);
    cyc(1); expect_all("post_rst_c3", 32'h088, 1'b1, 32'h8000_0003, 1'b0);

    // trap_ack and mret together in REQ: ack wins.
    trap_ack = 1'b1; mret = 1'b1;
    cyc(1); expect_all("ack_mret", 32'h088, 1'b0, 32'h8000_0003, 1'b1);
    trap_ack = 1'b0; mret = 1'b0;
    cyc(2); expect_all("handler_stay", 32'h088, 1'b0, 32'h8000_0003, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
